// File: rtl/ysyx_220053_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220053_mem_resp
// Purpose  : Data-memory responder. Accepts one 64-bit-aligned request at a
//            time, performs a byte-masked write or a full-word read on an
//            internal word array, and answers after LAT cycles with
//            response-side backpressure.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_220053_mem_resp #(
    parameter int          AW   = 10,
    parameter logic [63:0] BASE = 64'h8000_0000,
    parameter int          LAT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int         DEPTH  = 1 << AW;
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  counter;
    logic        wen_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;

    logic [63:0] mem [0:DEPTH-1];

    // Offset from BASE in 64-bit unsigned arithmetic; an address below BASE
    // wraps to a huge offset and therefore lands out of range.
    logic [63:0]   offset;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          do_access;

    assign offset    = addr_q - BASE;
    assign in_range  = (offset >> (AW + 3)) == 64'd0;
    assign idx       = offset[AW+2:3];
    // The access happens on the edge that moves BUSY into RESP.
    assign do_access = (state == BUSY) && (counter == 4'd0);

    // Control FSM with registered handshake and response outputs.
    // Every request passes through BUSY so that the response always appears
    // exactly LAT edges after acceptance, including LAT == 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
            counter    <= 4'd0;
            wen_q      <= 1'b0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            wmask_q    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is high exactly while in IDLE
                    if (req_valid) begin
                        wen_q     <= req_wen;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wmask_q   <= req_wmask;
                        counter   <= LAT_M1;
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (counter == 4'd0) begin
                        resp_valid <= 1'b1;
                        resp_err   <= ~in_range;
                        resp_rdata <= (in_range && !wen_q) ? mem[idx] : 64'd0;
                        state      <= RESP;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= 64'd0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Byte-masked storage write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (do_access && wen_q && in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
